// File: rtl/rop_req_arbiter.sv
// Round-robin arbiter and credit controller feeding the shared ROP pipeline.
// Grants one port per cycle into a one-entry output register and tracks in-flight requests.
module rop_req_arbiter #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned DATAW       = 89,
    parameter int unsigned TAGW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    parameter int unsigned CNTW        = $clog2(MAX_PENDING + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQS-1:0]       req_valid_i,
    input  logic [NUM_REQS*DATAW-1:0] req_data_i,
    output logic [NUM_REQS-1:0]       req_ready_o,
    output logic                      out_valid_o,
    output logic [DATAW-1:0]          out_data_o,
    output logic [TAGW-1:0]           out_tag_o,
    input  logic                      out_ready_i,
    input  logic                      done_i,
    output logic [CNTW-1:0]           pending_o,
    output logic                      idle_o
);

    logic [TAGW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATAW-1:0]    out_data_q, out_data_d;
    logic [TAGW-1:0]     out_tag_q, out_tag_d;
    logic [CNTW-1:0]     pending_q, pending_d;
    logic                idle_q, idle_d;

    logic                accept_ok;
    logic                accept;
    logic                grant_found;
    logic [TAGW-1:0]     grant_idx;
    logic [NUM_REQS-1:0] grant_oh;
    logic [DATAW-1:0]    grant_data;
    int unsigned         idx;

    // No credit bypass from done: only the registered count gates acceptance.
    assign accept_ok = !reset_i && (pending_q < CNTW'(MAX_PENDING)) &&
                       (!out_valid_q || out_ready_i);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_data  = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQS;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found   = 1'b1;
                grant_idx     = idx[TAGW-1:0];
                grant_oh[idx] = 1'b1;
                grant_data    = req_data_i[idx*DATAW +: DATAW];
            end
        end
    end

    assign accept      = accept_ok && grant_found;
    assign req_ready_o = accept ? grant_oh : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        pending_d   = pending_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_tag_d   = grant_idx;
            rr_ptr_d    = (grant_idx == TAGW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        unique case ({accept, done_i})
            2'b10:   pending_d = pending_q + CNTW'(1);
            2'b01:   pending_d = (pending_q != '0) ? pending_q - CNTW'(1) : '0;
            default: pending_d = pending_q;
        endcase

        idle_d = (pending_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            pending_q   <= '0;
            idle_q      <= 1'b1;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            pending_q   <= pending_d;
            idle_q      <= idle_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;
    assign pending_o   = pending_q;
    assign idle_o      = idle_q;

endmodule
